card_shoe: RTL and testbench
============================

# card_shoe

Card source for the blackjack table. Holds a 52-card deck in registers, shuffles it with a deterministic 51-cycle Fisher–Yates pass driven by an LFSR, and deals two card values per request on `on`. It re-shuffles automatically when the shoe runs low. It is the producer end of the `on` / `card1_out` / `card2_out` interface consumed by the game FSM.

## Interface
- `DECK_SIZE`, 52: cards in the shoe; must be even and at most 63.
- `RESHUFFLE_AT`, 16: a deal that leaves `cards_left < RESHUFFLE_AT` triggers a reshuffle.
- `SEED`, 16'hACE1: LFSR reset value; must be nonzero.
- `clk  in  1`: clock; all logic is on the rising edge.
- `reset_n  in  1`: reset, asynchronous, active-low.
- `on  in  1`: deal request, level-sampled; each cycle it is high while `ready`=1 is one deal.
- `test  in  3`: 0 means shuffled play; any nonzero value skips the permutation and deals in fill order. Sampled on entry to SHUFFLE.
- `card1_out  out  4`: first card value of the last deal, 1..10 (ace=1).
- `card2_out  out  4`: second card value of the last deal.
- `card_valid  out  1`: one-cycle strobe; the card outputs changed at this edge.
- `ready  out  1`: shoe accepts `on` this cycle.
- `shuffle_busy  out  1`: high during FILL or SHUFFLE.
- `cards_left  out  6`: undealt cards.

## Operation
- Deck storage: `deck[0..DECK_SIZE-1]`, 4-bit rank 1..13.
- Output value: rank ≥ 10 maps to 10; otherwise the value equals the rank.
- States:
  - FILL: write `deck[k] = (k mod 13)+1` for k = 0..DECK_SIZE-1, one entry per cycle; go to SHUFFLE.
  - SHUFFLE: index i runs from DECK_SIZE-1 down to 1, one step per cycle. Each step computes `j = (lfsr[5:0]*(i+1)) >> 6`, giving 0 ≤ j ≤ i, and swaps `deck[i]` with `deck[j]`. If `test`≠0, no swap is performed but the step is still taken. After i=1: ptr=0, `cards_left`=DECK_SIZE, go to IDLE.
  - IDLE: `ready`=1.
- Deal in IDLE when `on`=1:
  - Load `card1_out`=val(`deck[ptr]`) and `card2_out`=val(`deck[ptr+1]`).
  - ptr += 2, `cards_left` -= 2, `card_valid`=1.
  - If the new `cards_left < RESHUFFLE_AT`, go to SHUFFLE; otherwise stay in IDLE.
- Reshuffle permutes the whole array, including already-dealt cards; the array remains a permutation of the full deck. FILL runs only after reset.
- LFSR: 16-bit Galois, taps mask 16'hB400. It advances every cycle in every state, so the timing of requests perturbs the shuffle.
- Requests while `ready`=0 are dropped, not queued.
- `card1_out`/`card2_out` hold their value between deals and through a reshuffle.
- Arithmetic: `j` is the 6×6 product's bits [11:6]. ptr and `cards_left` are 6 bits. `cards_left` is always even, so a deal never underflows (reshuffle happens first).

## Timing
- Reset values: `card1_out`=0, `card2_out`=0, `card_valid`=0, `ready`=0, `shuffle_busy`=1, `cards_left`=0, lfsr=SEED, state=FILL.
- After reset release:
  - FILL takes DECK_SIZE cycles and SHUFFLE takes DECK_SIZE-1 cycles.
  - `ready` rises at edge 103 for the defaults, whether or not `test` is set.
- Deal latency: `on` is sampled at edge N, and the new cards plus `card_valid` are visible right after edge N. There is one deal per cycle, and back-to-back deals are allowed.
- The reshuffling deal drops `ready` after the same edge. SHUFFLE then takes DECK_SIZE-1 cycles before `ready`=1 again.
- `card_valid` is never high for two cycles without `on` being high in IDLE for both of those cycles.
- Asserting `reset_n` low mid-SHUFFLE or mid-deal immediately forces the reset values and restarts at FILL.
- `ready` and `shuffle_busy` are complementary outside reset.

## Structure
- Package `card_shoe_pkg`:
  - state encoding (FILL, SHUFFLE, IDLE)
  - `DECK_SIZE_DEF`
  - `LFSR_TAPS` = 16'hB400
  - rank-to-value function
- Sub-module `shoe_lfsr`: 16-bit Galois LFSR with a SEED parameter and async active-low reset, free-running.

## Test plan
- Reset, `test`=1, hold `on`=0: `ready` rises after 103 cycles with `cards_left`=52. The first deal gives 1,2 with `cards_left`=50. The 7th deal gives 10,1 (K, A).
- `test`=1, `on` held high continuously: 19 consecutive `card_valid` pulses occur. The 19th leaves `cards_left`=14, `ready` drops for 51 cycles, then `cards_left`=52 and the next deal again gives 1,2.
- `test`=0, deal the whole shoe across reshuffles (capture deck by forcing `RESHUFFLE_AT`=2): the histogram over 26 deals is exactly four each of values 1–9 and sixteen 10s.
- `on` pulsed during FILL/SHUFFLE: no `card_valid`, `cards_left` unchanged, and the request is not serviced later.
- `reset_n` low for 1 cycle mid-SHUFFLE, asynchronously: outputs go to reset values before the next edge. The sequence with `test`=0 replays identically to a clean reset with the same request timing.
- Two benches with the same SEED and same request timing deal identical sequences. Delaying the first request by 1 cycle changes the post-reshuffle sequence.

Source files
------------

// File: rtl/card_shoe_pkg.sv
// Shared types and constants for the card shoe: FSM states, deck size, LFSR taps.
// Also holds the rank-to-value mapping used when cards are dealt.
package card_shoe_pkg;

   typedef enum logic [1:0] {
      ST_FILL    = 2'd0,
      ST_SHUFFLE = 2'd1,
      ST_IDLE    = 2'd2
   } state_t;

   localparam int          DECK_SIZE_DEF = 52;
   localparam int          RANKS         = 13;
   localparam logic [15:0] LFSR_TAPS     = 16'hB400;

   // Face cards (J, Q, K) are all worth ten.
   function automatic logic [3:0] rank_to_val(input logic [3:0] rank);
      return (rank >= 4'd10) ? 4'd10 : rank;
   endfunction

endpackage

// File: rtl/shoe_lfsr.sv
// Free-running 16-bit Galois LFSR, one step per clock in every state; no backpressure.
// Exposes only the low OUT_W bits that the shuffle consumes.
module shoe_lfsr import card_shoe_pkg::*; #(
   parameter logic [15:0] SEED  = 16'hACE1,
   parameter int          OUT_W = 6
) (
   input  logic             clk,
   input  logic             reset_n,
   output logic [OUT_W-1:0] rnd
);

   logic [15:0] lfsr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lfsr <= SEED;
      end else begin
         lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
      end
   end

   assign rnd = lfsr[OUT_W-1:0];

endmodule

// File: rtl/card_shoe.sv
// Register-held 52-card shoe: fill, LFSR-driven Fisher-Yates shuffle, two cards per deal.
// Deal visible right after the sampling edge; requests while not ready are dropped.
module card_shoe import card_shoe_pkg::*; #(
   parameter int          DECK_SIZE    = DECK_SIZE_DEF,
   parameter int          RESHUFFLE_AT = 16,
   parameter logic [15:0] SEED         = 16'hACE1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       on,
   input  logic [2:0] test,
   output logic [3:0] card1_out,
   output logic [3:0] card2_out,
   output logic       card_valid,
   output logic       ready,
   output logic       shuffle_busy,
   output logic [5:0] cards_left
);

   localparam logic [5:0] LAST = 6'(DECK_SIZE - 1);
   localparam logic [5:0] FULL = 6'(DECK_SIZE);
   localparam logic [5:0] LOW  = 6'(RESHUFFLE_AT);

   state_t     state, state_nxt;
   logic [3:0] deck [DECK_SIZE];
   logic [5:0] fill_idx;
   logic [3:0] fill_rank;
   logic [5:0] step_idx;
   logic [5:0] step_p1;
   logic [5:0] swap_j;
   logic [5:0] ptr;
   logic [5:0] ptr_p1;
   logic [5:0] left_after;
   logic [5:0] rnd;
   logic       test_q;
   logic       fill_we;
   logic       swap_en;
   logic       deal;
   logic       enter_shuffle;
   logic       shuffle_done;

   shoe_lfsr #(
      .SEED  (SEED),
      .OUT_W (6)
   ) u_lfsr (
      .clk     (clk),
      .reset_n (reset_n),
      .rnd     (rnd)
   );

   assign step_p1    = step_idx + 6'd1;
   // Scaling a 6-bit random by (i+1) and keeping the top half lands j in 0..i.
   assign swap_j     = 6'(({6'd0, rnd} * {6'd0, step_p1}) >> 6);
   assign ptr_p1     = ptr + 6'd1;
   assign left_after = cards_left - 6'd2;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_FILL;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      fill_we       = 1'b0;
      swap_en       = 1'b0;
      deal          = 1'b0;
      enter_shuffle = 1'b0;
      shuffle_done  = 1'b0;
      case (state)
         ST_FILL: begin
            fill_we = 1'b1;
            if (fill_idx == LAST) begin
               state_nxt     = ST_SHUFFLE;
               enter_shuffle = 1'b1;
            end
         end
         ST_SHUFFLE: begin
            swap_en = ~test_q;
            if (step_idx == 6'd1) begin
               state_nxt    = ST_IDLE;
               shuffle_done = 1'b1;
            end
         end
         ST_IDLE: begin
            if (on) begin
               deal = 1'b1;
               if (left_after < LOW) begin
                  state_nxt     = ST_SHUFFLE;
                  enter_shuffle = 1'b1;
               end
            end
         end
         default: state_nxt = ST_FILL;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fill_idx   <= 6'd0;
         fill_rank  <= 4'd1;
         step_idx   <= 6'd0;
         test_q     <= 1'b0;
         ptr        <= 6'd0;
         cards_left <= 6'd0;
         card1_out  <= 4'd0;
         card2_out  <= 4'd0;
         card_valid <= 1'b0;
      end else begin
         card_valid <= deal;
         if (fill_we) begin
            fill_idx  <= fill_idx + 6'd1;
            fill_rank <= (fill_rank == 4'(RANKS)) ? 4'd1 : fill_rank + 4'd1;
         end
         if (enter_shuffle) begin
            step_idx <= LAST;
            test_q   <= |test;
         end else if (state == ST_SHUFFLE) begin
            step_idx <= step_idx - 6'd1;
         end
         if (shuffle_done) begin
            ptr        <= 6'd0;
            cards_left <= FULL;
         end else if (deal) begin
            card1_out  <= rank_to_val(deck[ptr]);
            card2_out  <= rank_to_val(deck[ptr_p1]);
            ptr        <= ptr + 6'd2;
            cards_left <= left_after;
         end
      end
   end

   // Deck contents are fully rewritten by FILL after every reset, so no reset here.
   always_ff @(posedge clk) begin
      if (fill_we) begin
         deck[fill_idx] <= fill_rank;
      end else if (swap_en) begin
         deck[step_idx] <= deck[swap_j];
         deck[swap_j]   <= deck[step_idx];
      end
   end

   assign ready        = (state == ST_IDLE);
   assign shuffle_busy = (state == ST_FILL) || (state == ST_SHUFFLE);

endmodule

// File: tb/tb_card_shoe.sv
// Random-request bench for card_shoe against a transaction-level shoe model.
module tb_card_shoe;

   localparam int          DS   = 52;
   localparam int          RA   = 16;
   localparam logic [15:0] SEED = 16'hACE1;
   localparam int          HMAX = 4096;
   localparam int          PLEN = 500;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       on;
   logic [2:0] test;
   logic [3:0] card1_out, card2_out;
   logic       card_valid, ready, shuffle_busy;
   logic [5:0] cards_left;

   logic       rst2_n, on2;
   logic [2:0] test2;
   logic [3:0] c1_2, c2_2;
   logic       valid2, ready2, busy2;
   logic [5:0] left2;
   bit         hist_done = 1'b0;

   always #5 clk = ~clk;

   card_shoe #(.DECK_SIZE(DS), .RESHUFFLE_AT(RA), .SEED(SEED)) dut (
      .clk(clk), .reset_n(reset_n), .on(on), .test(test),
      .card1_out(card1_out), .card2_out(card2_out), .card_valid(card_valid),
      .ready(ready), .shuffle_busy(shuffle_busy), .cards_left(cards_left)
   );

   card_shoe #(.DECK_SIZE(DS), .RESHUFFLE_AT(2), .SEED(SEED)) dut2 (
      .clk(clk), .reset_n(rst2_n), .on(on2), .test(test2),
      .card1_out(c1_2), .card2_out(c2_2), .card_valid(valid2),
      .ready(ready2), .shuffle_busy(busy2), .cards_left(left2)
   );

   int checks = 0;
   int errors = 0;

   // model state
   logic [15:0] hist [HMAX];
   int m_edge, m_ready_at, m_ptr, m_cl, m_c1, m_c2;
   bit m_valid;
   int m_deck [DS];
   bit pat [PLEN];
   logic [7:0] rec[$], rec_a[$], rec_b[$], rec_c[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s (edge %0d): got %0d expected %0d", tag, m_edge, got, exp);
      end
   endtask

   function automatic int val_of(input int r);
      return (r >= 10) ? 10 : r;
   endfunction

   function automatic bit m_ready();
      return m_edge >= m_ready_at;
   endfunction

   // Fisher-Yates over the whole array; step i happens DS-1-i edges after entry e0.
   task automatic m_shuffle(input int e0, input int t);
      for (int i = DS - 1; i >= 1; i--) begin
         int r, j, tmp;
         r = int'(hist[e0 + DS - 1 - i]) % 64;
         j = (r * (i + 1)) / 64;
         if (t == 0) begin
            tmp = m_deck[i];
            m_deck[i] = m_deck[j];
            m_deck[j] = tmp;
         end
      end
   endtask

   task automatic m_reset();
      m_edge = 0; m_ready_at = 1 << 30; m_ptr = 0; m_cl = 0;
      m_c1 = 0; m_c2 = 0; m_valid = 1'b0;
   endtask

   task automatic m_step(input bit on_v, input int t);
      m_edge++;
      m_valid = 1'b0;
      if (m_edge + DS >= HMAX) begin
         $display("FAIL model_range: edge %0d beyond table", m_edge);
         $fatal(1);
      end
      if (m_edge == DS) begin
         for (int k = 0; k < DS; k++) m_deck[k] = (k % 13) + 1;
         m_shuffle(m_edge, t);
         m_ready_at = m_edge + DS - 1;
      end else if (m_edge == m_ready_at) begin
         m_cl = DS;
         m_ptr = 0;
      end else if (m_edge - 1 >= m_ready_at && on_v) begin
         m_c1 = val_of(m_deck[m_ptr]);
         m_c2 = val_of(m_deck[m_ptr + 1]);
         m_ptr += 2;
         m_cl -= 2;
         m_valid = 1'b1;
         if (m_cl < RA) begin
            m_shuffle(m_edge, t);
            m_ready_at = m_edge + DS - 1;
         end
      end
   endtask

   task automatic run_cycle(input bit on_v, input logic [2:0] t_v);
      on = on_v;
      test = t_v;
      @(posedge clk);
      m_step(on_v, (t_v != 3'd0) ? 1 : 0);
      @(negedge clk);
      check("valid", card_valid, m_valid);
      check("ready", ready, m_ready());
      check("busy", shuffle_busy, !m_ready());
      check("left", cards_left, m_cl);
      check("card1", card1_out, m_c1);
      check("card2", card2_out, m_c2);
      if (card_valid) rec.push_back({card1_out, card2_out});
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_c1"}, card1_out, 0);
      check({tag, "_c2"}, card2_out, 0);
      check({tag, "_valid"}, card_valid, 0);
      check({tag, "_ready"}, ready, 0);
      check({tag, "_busy"}, shuffle_busy, 1);
      check({tag, "_left"}, cards_left, 0);
   endtask

   // Called at a falling edge; reset is asserted between clock edges.
   task automatic do_reset();
      #2 reset_n = 1'b0;
      #1 check_reset_vals("async_rst");
      m_reset();
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic run_pattern(input int delay);
      rec.delete();
      do_reset();
      repeat (delay) run_cycle(1'b0, 3'd0);
      for (int k = 0; k < PLEN; k++) run_cycle(pat[k], 3'd0);
   endtask

   initial begin
      int pulses, n, mism, diff, w, lim;
      reset_n = 1'b0; on = 1'b0; test = 3'd1;
      hist[0] = SEED;
      for (int k = 0; k < HMAX - 1; k++)
         hist[k + 1] = (hist[k] >> 1) ^ (hist[k][0] ? 16'hB400 : 16'h0000);
      for (int k = 0; k < PLEN; k++) pat[k] = 1'($urandom % 2);
      m_reset();
      @(negedge clk);
      @(negedge clk);
      check_reset_vals("por");
      reset_n = 1'b1;

      // test mode, no requests until ready
      repeat (2 * DS - 1) run_cycle(1'b0, 3'd1);
      check("ready_edge103", ready, 1);
      check("left_full", cards_left, DS);

      // continuous requests in fill order
      pulses = 0; n = 0;
      do begin
         run_cycle(1'b1, 3'd1);
         n++;
         if (card_valid) begin
            pulses++;
            if (pulses == 1) begin
               check("deal1_c1", card1_out, 1);
               check("deal1_c2", card2_out, 2);
               check("deal1_left", cards_left, 50);
            end
            if (pulses == 7) begin
               check("deal7_c1", card1_out, 10);
               check("deal7_c2", card2_out, 1);
            end
         end
      end while (ready && n < 100);
      check("pulses", pulses, 19);
      check("left_low", cards_left, 14);
      n = 0;
      do begin
         run_cycle(1'b1, 3'd1);
         n++;
      end while (!ready && n < 200);
      check("reshuffle_len", n, 51);
      check("left_refill", cards_left, DS);
      run_cycle(1'b1, 3'd1);
      check("redeal_c1", card1_out, 1);
      check("redeal_c2", card2_out, 2);

      // random play, mostly shuffled
      for (int k = 0; k < 600; k++)
         run_cycle(1'($urandom % 2), ($urandom % 8 == 0) ? 3'($urandom_range(1, 7)) : 3'd0);

      // replay after clean reset vs. after a mid-shuffle reset
      run_pattern(0);
      rec_a = rec;
      n = 0;
      while (ready && n < 200) begin run_cycle(1'b1, 3'd0); n++; end
      repeat (10) run_cycle(1'b0, 3'd0);
      check("busy_before_rst", shuffle_busy, 1);
      run_pattern(0);
      rec_b = rec;
      check("replay_len", rec_b.size(), rec_a.size());
      check("enough_deals", (rec_a.size() >= 40) ? 1 : 0, 1);
      mism = 0;
      lim = (rec_a.size() < rec_b.size()) ? rec_a.size() : rec_b.size();
      for (int k = 0; k < lim; k++) if (rec_a[k] !== rec_b[k]) mism++;
      check("replay_seq", mism, 0);

      // one-cycle delay of the request stream
      run_pattern(1);
      rec_c = rec;
      mism = 0; diff = 0;
      lim = (rec_a.size() < rec_c.size()) ? rec_a.size() : rec_c.size();
      for (int k = 0; k < lim; k++) begin
         if (k < 19 && rec_a[k] !== rec_c[k]) mism++;
         if (k >= 19 && rec_a[k] !== rec_c[k]) diff++;
      end
      check("delay_pre_same", mism, 0);
      check("delay_post_differs", (diff > 0) ? 1 : 0, 1);

      w = 0;
      while (!hist_done && w < 1000) begin @(negedge clk); w++; end
      check("hist_finished", hist_done, 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Full-deck histogram from an instance that reshuffles only when empty.
   initial begin
      int cnt [11];
      int deals, cyc;
      for (int v = 0; v < 11; v++) cnt[v] = 0;
      deals = 0; cyc = 0;
      rst2_n = 1'b0; on2 = 1'b1; test2 = 3'd0;
      @(negedge clk);
      @(negedge clk);
      rst2_n = 1'b1;
      while (deals < 26 && cyc < 500) begin
         @(negedge clk);
         cyc++;
         if (valid2) begin
            deals++;
            if (c1_2 >= 4'd1 && c1_2 <= 4'd10) cnt[c1_2]++; else cnt[0]++;
            if (c2_2 >= 4'd1 && c2_2 <= 4'd10) cnt[c2_2]++; else cnt[0]++;
         end
      end
      check("hist_deals", deals, 26);
      for (int v = 1; v <= 9; v++) check($sformatf("hist_v%0d", v), cnt[v], 4);
      check("hist_v10", cnt[10], 16);
      check("hist_bad", cnt[0], 0);
      hist_done = 1'b1;
   end

endmodule
